// File: rtl/ibex_pkg.sv
// Shared types and helpers for the LSU data-encryption shim.
// Holds the FSM state encoding and the keystream round function.
package ibex_pkg;

  typedef enum logic [2:0] {
    CS_IDLE,
    CS_GEN,
    CS_REQ,
    CS_WAIT,
    CS_ERR
  } crypt_state_e;

  localparam int unsigned CryptRot = 5;

  function automatic logic [31:0] crypt_round(
    input logic [31:0] ks,
    input logic [31:0] key
  );
    return {ks[31-CryptRot:0], ks[31:32-CryptRot]} ^ (ks + key);
  endfunction

endpackage

// File: rtl/ibex_crypt_keystream.sv
// Keystream generator: seeds from key/address on load and runs
// one mixing round per step; done marks the final round.
module ibex_crypt_keystream
  import ibex_pkg::*;
#(
  parameter int unsigned CryptRounds = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        load_i,
  input  logic        enc_i,
  input  logic        step_i,
  input  logic [31:0] key_i,
  input  logic [31:0] addr_i,
  output logic [31:0] ks_o,
  output logic        done_o
);

  logic [31:0] ks_q, ks_d;
  logic [31:0] key_q, key_d;
  logic [3:0]  cnt_q, cnt_d;

  always_comb begin
    ks_d  = ks_q;
    key_d = key_q;
    cnt_d = cnt_q;
    if (load_i) begin
      key_d = key_i;
      cnt_d = '0;
      // Bypass accesses keep a zero keystream so the XORs are no-ops
      ks_d  = enc_i ? (key_i ^ {addr_i[31:2], 2'b00}) : '0;
    end else if (step_i) begin
      ks_d  = crypt_round(ks_q, key_q);
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ks_q  <= '0;
      key_q <= '0;
      cnt_q <= '0;
    end else begin
      ks_q  <= ks_d;
      key_q <= key_d;
      cnt_q <= cnt_d;
    end
  end

  assign ks_o   = ks_q;
  assign done_o = (cnt_q == 4'(CryptRounds - 1));

endmodule

// File: rtl/ibex_data_crypt.sv
// LSU-to-bus shim that XOR-encrypts data words with a per-access
// keystream when the PMP region carries the encrypt attribute.
module ibex_data_crypt
  import ibex_pkg::*;
#(
  parameter int unsigned CryptRounds = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        lsu_req_i,
  output logic        lsu_gnt_o,
  input  logic [31:0] lsu_addr_i,
  input  logic        lsu_we_i,
  input  logic [3:0]  lsu_be_i,
  input  logic [31:0] lsu_wdata_i,
  input  logic        pmp_err_i,
  input  logic        pmp_enc_i,
  input  logic [31:0] key_i,
  output logic        lsu_rvalid_o,
  output logic [31:0] lsu_rdata_o,
  output logic        lsu_err_o,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  output logic [31:0] data_addr_o,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_wdata_o,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i,
  input  logic        data_err_i
);

  crypt_state_e state_q, state_d;
  logic [31:0]  addr_q, addr_d;
  logic [31:0]  wdata_q, wdata_d;
  logic [3:0]   be_q, be_d;
  logic         we_q, we_d;
  logic         accept;
  logic [31:0]  ks;
  logic         ks_done;

  assign accept = (state_q == CS_IDLE) && lsu_req_i;

  ibex_crypt_keystream #(
    .CryptRounds(CryptRounds)
  ) u_ks (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .load_i(accept),
    .enc_i (pmp_enc_i),
    .step_i(state_q == CS_GEN),
    .key_i (key_i),
    .addr_i(lsu_addr_i),
    .ks_o  (ks),
    .done_o(ks_done)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    we_d    = we_q;
    unique case (state_q)
      CS_IDLE: begin
        if (lsu_req_i) begin
          addr_d  = lsu_addr_i;
          wdata_d = lsu_wdata_i;
          be_d    = lsu_be_i;
          we_d    = lsu_we_i;
          if (pmp_err_i)      state_d = CS_ERR;
          else if (pmp_enc_i) state_d = CS_GEN;
          else                state_d = CS_REQ;
        end
      end
      CS_GEN:  if (ks_done) state_d = CS_REQ;
      CS_REQ:  if (data_gnt_i) state_d = CS_WAIT;
      CS_WAIT: if (data_rvalid_i) state_d = CS_IDLE;
      CS_ERR:  state_d = CS_IDLE;
      default: state_d = CS_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= CS_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      we_q    <= we_d;
    end
  end

  logic in_req, rsp, rsp_ok;
  assign in_req = (state_q == CS_REQ);
  assign rsp    = (state_q == CS_WAIT) && data_rvalid_i;
  assign rsp_ok = rsp && !we_q && !data_err_i;

  assign lsu_gnt_o    = accept;
  assign data_req_o   = in_req;
  assign data_addr_o  = in_req ? addr_q : '0;
  assign data_we_o    = in_req && we_q;
  assign data_be_o    = in_req ? be_q : '0;
  assign data_wdata_o = (in_req && we_q) ? (wdata_q ^ ks) : '0;
  assign lsu_rvalid_o = rsp || (state_q == CS_ERR);
  assign lsu_err_o    = (rsp && data_err_i) || (state_q == CS_ERR);
  assign lsu_rdata_o  = rsp_ok ? (data_rdata_i ^ ks) : '0;

endmodule
